// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file: clear FSM encoding and defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package regfile_pkg;

    // Clear sequencer states, kept as plain 2-bit constants for legacy compatibility
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Ceiling log2, used to derive address widths from depths at elaboration
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    localparam int DEF_DW    = 32;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_AW    = clog2(DEF_DEPTH);

endpackage

// File: rtl/regfile_param_if.sv
// Bundles the write port, packed read ports and clear handshake of the register file.
// Latency: n/a (wiring only).
// Backpressure: none; writes are fire-and-forget, clear uses req/busy/done.
interface regfile_param_if
    import regfile_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int AW     = DEF_AW,
    parameter int NUM_RD = 2
);
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [DW-1:0]        wr_data;
    logic [NUM_RD*AW-1:0] rd_addr;
    logic [NUM_RD*DW-1:0] rd_data;
    logic                 clr_req;
    logic                 clr_busy;
    logic                 clr_done;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, clr_req,
        input  rd_data, clr_busy, clr_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, clr_req,
        output rd_data, clr_busy, clr_done
    );
endinterface

// File: rtl/regfile_clr_fsm.sv
// Background clear sequencer: sweeps the array zeroing one entry per cycle.
// Latency: busy for exactly DEPTH cycles after the request edge, then a one-cycle done.
// Backpressure: clr_req only sampled in IDLE; held requests do not retrigger from DONE.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          clr_req,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic          clr_busy,
    output logic          clr_done
);
    // Pointer carries one extra bit so DEPTH == 2**AW ends without wrapping
    localparam int          LAST_I = DEPTH - 1;
    localparam logic [AW:0] LAST   = LAST_I[AW:0];

    logic [1:0]  state_q, state_d;
    logic [AW:0] ptr_q, ptr_d;

    // Next-state and pointer advance for the sweep
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and pointer registers; reset aborts any sweep in flight
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign clr_busy = (state_q == ST_CLEAR);
    assign clr_done = (state_q == ST_DONE);
    assign clr_we   = clr_busy;
    assign clr_addr = ptr_q[AW-1:0];

endmodule

// File: rtl/regfile_param.sv
// Multi-read-port register file with write bypass, optional zero register and background clear.
// Latency: reads combinational (READ_REG=0) or one cycle (READ_REG=1); writes land at the edge.
// Backpressure: none; writes during a clear sweep and to unmapped addresses are dropped.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AW        = DEF_AW,
    parameter int NUM_RD    = 2,
    parameter int ZERO_REG0 = 1,
    parameter int READ_REG  = 0
) (
    input  logic           clk,
    input  logic           nrst,
    regfile_param_if.slave bus
);
    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

    logic [DW-1:0]             mem_q [DEPTH];
    logic [DW-1:0]             mem_d [DEPTH];
    logic                      clr_we;
    logic [AW-1:0]             clr_addr;
    logic                      wr_vld;
    logic [NUM_RD-1:0][DW-1:0] rd_val;

    regfile_clr_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr_fsm (
        .clk      (clk),
        .nrst     (nrst),
        .clr_req  (bus.clr_req),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .clr_busy (bus.clr_busy),
        .clr_done (bus.clr_done)
    );

    // A write counts only outside a sweep, inside the array and away from a hardwired zero entry
    assign wr_vld = bus.wr_en && !clr_we
                 && ({1'b0, bus.wr_addr} < DEPTH_W)
                 && !((ZERO_REG0 != 0) && (bus.wr_addr == '0));

    // Array update: either the user write or the sweep zeroing, never both in one cycle
    always_comb begin
        mem_d = mem_q;
        if (wr_vld) begin
            mem_d[bus.wr_addr] = bus.wr_data;
        end
        if (clr_we) begin
            mem_d[clr_addr] = '0;
        end
    end

    // Array storage; reset wipes every entry in a single edge
    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Independent read ports: unmapped/zero addresses read 0, a same-cycle write is forwarded
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic          ra_zero;
        assign ra      = bus.rd_addr[k*AW +: AW];
        assign ra_zero = ({1'b0, ra} >= DEPTH_W) || ((ZERO_REG0 != 0) && (ra == '0));
        assign rd_val[k] = ra_zero                        ? '0 :
                           (wr_vld && bus.wr_addr == ra)  ? bus.wr_data :
                                                            mem_q[ra];
    end

    if (READ_REG != 0) begin : g_rd_reg
        logic [NUM_RD*DW-1:0] rd_data_q, rd_data_d;

        // Capture the bypassed read value for presentation next cycle
        always_comb begin
            rd_data_d = rd_val;
        end

        // Output register for the registered-read configuration
        always_ff @(posedge clk) begin
            if (!nrst) begin
                rd_data_q <= '0;
            end else begin
                rd_data_q <= rd_data_d;
            end
        end

        assign bus.rd_data = rd_data_q;
    end else begin : g_rd_comb
        assign bus.rd_data = rd_val;
    end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: three instances cover combinational read,
// registered read and a non-power-of-two depth.
// Each comparison is an immediate assertion against a hand-computed value.
module tb_regfile_param;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_param_if #(.DW(32), .AW(5), .NUM_RD(2)) if0 ();
    regfile_param_if #(.DW(32), .AW(5), .NUM_RD(2)) if1 ();
    regfile_param_if #(.DW(32), .AW(5), .NUM_RD(2)) if2 ();

    regfile_param #(.DW(32), .DEPTH(32), .AW(5), .NUM_RD(2), .ZERO_REG0(1), .READ_REG(0))
        dut0 (.clk(clk), .nrst(nrst), .bus(if0));
    regfile_param #(.DW(32), .DEPTH(32), .AW(5), .NUM_RD(2), .ZERO_REG0(1), .READ_REG(1))
        dut1 (.clk(clk), .nrst(nrst), .bus(if1));
    regfile_param #(.DW(32), .DEPTH(20), .AW(5), .NUM_RD(2), .ZERO_REG0(1), .READ_REG(0))
        dut2 (.clk(clk), .nrst(nrst), .bus(if2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr0(input logic [4:0] a, input logic [31:0] d);
        if0.wr_en   = 1'b1;
        if0.wr_addr = a;
        if0.wr_data = d;
        tick();
        if0.wr_en   = 1'b0;
    endtask

    task automatic wr2(input logic [4:0] a, input logic [31:0] d);
        if2.wr_en   = 1'b1;
        if2.wr_addr = a;
        if2.wr_data = d;
        tick();
        if2.wr_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cnt;
        logic [31:0] acc;
        logic [31:0] exp;
        logic        seen;
        int          bad;

        if0.wr_en = 0; if0.wr_addr = '0; if0.wr_data = '0; if0.rd_addr = '0; if0.clr_req = 0;
        if1.wr_en = 0; if1.wr_addr = '0; if1.wr_data = '0; if1.rd_addr = '0; if1.clr_req = 0;
        if2.wr_en = 0; if2.wr_addr = '0; if2.wr_data = '0; if2.rd_addr = '0; if2.clr_req = 0;

        tick();
        tick();
        nrst = 1'b1;

        // Reset wipes a written entry and all outputs
        wr0(5'd5, 32'hDEADBEEF);
        if0.rd_addr = {5'd5, 5'd5};
        #1;
        chk("pre_reset_wr", if0.rd_data[31:0], 32'hDEADBEEF);
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        #1;
        chk("reset_rd5_p0", if0.rd_data[31:0], 32'h0);
        chk("reset_rd5_p1", if0.rd_data[63:32], 32'h0);
        chk("reset_busy", {31'd0, if0.clr_busy}, 32'd0);
        chk("reset_done", {31'd0, if0.clr_done}, 32'd0);
        chk("reset_reg_rd", if1.rd_data[31:0], 32'h0);

        // Plain write/read and hardwired zero entry
        wr0(5'd3, 32'h12345678);
        wr0(5'd0, 32'hFFFFFFFF);
        if0.rd_addr = {5'd0, 5'd3};
        #1;
        chk("rd_addr3", if0.rd_data[31:0], 32'h12345678);
        chk("rd_zero_reg", if0.rd_data[63:32], 32'h0);

        // No bypass into the zero entry
        if0.wr_en = 1'b1; if0.wr_addr = 5'd0; if0.wr_data = 32'hFFFFFFFF;
        #1;
        chk("zero_reg_nobypass", if0.rd_data[63:32], 32'h0);
        tick();
        if0.wr_en = 1'b0;

        // Bypass: combinational instance sees it now, registered instance one edge later
        if0.wr_en = 1'b1; if0.wr_addr = 5'd7; if0.wr_data = 32'hA5A5A5A5; if0.rd_addr = {5'd3, 5'd7};
        if1.wr_en = 1'b1; if1.wr_addr = 5'd7; if1.wr_data = 32'hA5A5A5A5; if1.rd_addr = {5'd0, 5'd7};
        #1;
        chk("byp_comb", if0.rd_data[31:0], 32'hA5A5A5A5);
        chk("byp_comb_other_port", if0.rd_data[63:32], 32'h12345678);
        chk("byp_reg_before_edge", if1.rd_data[31:0], 32'h0);
        tick();
        chk("byp_reg_after_edge", if1.rd_data[31:0], 32'hA5A5A5A5);
        if0.wr_en = 1'b0;
        if1.wr_en = 1'b0;
        #1;
        chk("wr_persist", if0.rd_data[31:0], 32'hA5A5A5A5);

        // Clear sweep over a fully populated array
        for (int i = 1; i < 32; i++) wr0(i[4:0], 32'(i));
        if0.rd_addr = {5'd12, 5'd31};
        #1;
        chk("fill_31", if0.rd_data[31:0], 32'd31);
        chk("fill_12", if0.rd_data[63:32], 32'd12);
        if0.clr_req = 1'b1;
        tick();
        if0.clr_req = 1'b0;
        cnt = 0;
        while (if0.clr_busy && cnt < 100) begin
            if (cnt == 0) begin
                if0.rd_addr = {5'd0, 5'd20};
                #1;
                chk("clr_unreached", if0.rd_data[31:0], 32'd20);
            end
            if (cnt == 20) begin
                if0.wr_en = 1'b1; if0.wr_addr = 5'd9; if0.wr_data = 32'h99;
                if0.rd_addr = {5'd25, 5'd9};
                #1;
                chk("clr_nobypass", if0.rd_data[31:0], 32'h0);
                chk("clr_unreached25", if0.rd_data[63:32], 32'd25);
            end
            if (cnt == 21) begin
                if0.rd_addr = {5'd25, 5'd20};
                #1;
                chk("clr_reached20", if0.rd_data[31:0], 32'h0);
            end
            tick();
            if0.wr_en = 1'b0;
            cnt++;
        end
        chk("busy_len", cnt, 32);
        chk("done_pulse", {31'd0, if0.clr_done}, 32'd1);
        chk("done_not_busy", {31'd0, if0.clr_busy}, 32'd0);
        tick();
        chk("done_one_cycle", {31'd0, if0.clr_done}, 32'd0);
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            if0.rd_addr = {5'd0, i[4:0]};
            #1;
            acc = acc | if0.rd_data[31:0];
        end
        chk("clr_all_zero", acc, 32'h0);

        // Reset in the middle of a sweep
        for (int i = 1; i < 32; i++) wr0(i[4:0], 32'(i));
        if0.clr_req = 1'b1;
        tick();
        if0.clr_req = 1'b0;
        cnt = 0;
        while (if0.clr_busy && cnt < 10) begin
            tick();
            cnt++;
        end
        chk("mid_clear_cycle", cnt, 10);
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        chk("abort_busy", {31'd0, if0.clr_busy}, 32'd0);
        chk("abort_done", {31'd0, if0.clr_done}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            tick();
            seen = seen | if0.clr_done | if0.clr_busy;
        end
        chk("abort_no_done", {31'd0, seen}, 32'd0);
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            if0.rd_addr = {5'd0, i[4:0]};
            #1;
            acc = acc | if0.rd_data[31:0];
        end
        chk("abort_all_zero", acc, 32'h0);

        // Out-of-range addresses on the 20-entry instance
        for (int i = 1; i < 20; i++) wr2(i[4:0], 32'h100 + 32'(i));
        if2.wr_en = 1'b1; if2.wr_addr = 5'd25; if2.wr_data = 32'h00000BAD;
        if2.rd_addr = {5'd19, 5'd25};
        #1;
        chk("oor_nobypass", if2.rd_data[31:0], 32'h0);
        chk("last_entry", if2.rd_data[63:32], 32'h113);
        tick();
        if2.wr_en = 1'b0;
        if2.rd_addr = {5'd20, 5'd25};
        #1;
        chk("oor_rd25", if2.rd_data[31:0], 32'h0);
        chk("oor_rd20", if2.rd_data[63:32], 32'h0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if2.rd_addr = {5'd0, i[4:0]};
            #1;
            exp = (i == 0) ? 32'h0 : 32'h100 + 32'(i);
            if (if2.rd_data[31:0] !== exp) bad++;
        end
        chk("oor_entries_intact", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
